// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares a single D$ request port between NUM_PORTS requesters.
//   PRIO_PORT (the page-table walker) always wins; the other ports are
//   served round-robin. One request is in flight at a time.
//
// Handshake: a port holds req_valid with its request fields stable. The
//   arbiter accepts it by pulsing req_ready for exactly one cycle, and the
//   request is then owned by the arbiter. The port sees one resp_rvalid or
//   resp_write_done pulse on completion, unless it raised req_kill.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   virtual_en            global virtual-mode enable
//   req_valid/addr/write/wdata/wlen/kill   per-port request (flattened, port i in slice i)
//   req_ready             per-port one-cycle accept pulse
//   resp_rdata            shared read data (0 unless a resp_rvalid bit is set)
//   resp_rvalid           per-port read complete
//   resp_write_done       per-port write complete
//   dc_en, dc_write_en, dc_in_addr, dc_in_wdata, dc_in_wlen, dc_virtual_en  to D$
//   dc_rdata, dc_rvalid, dc_write_done                                      from D$
//   dbg_state             FSM state (0 IDLE, 1 BUSY, 2 DRAIN)
//   dbg_rr_ptr            round-robin pointer, zero-extended
module dcache_port_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int PRIO_PORT  = 0,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            virtual_en,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS*2-1:0]          req_wlen,
  input  logic [NUM_PORTS-1:0]            req_kill,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic [NUM_PORTS-1:0]            resp_rvalid,
  output logic [NUM_PORTS-1:0]            resp_write_done,
  output logic                            dc_en,
  output logic                            dc_write_en,
  output logic [ADDR_WIDTH-1:0]           dc_in_addr,
  output logic [DATA_WIDTH-1:0]           dc_in_wdata,
  output logic [1:0]                      dc_in_wlen,
  output logic                            dc_virtual_en,
  input  logic [DATA_WIDTH-1:0]           dc_rdata,
  input  logic                            dc_rvalid,
  input  logic                            dc_write_done,
  output logic [1:0]                      dbg_state,
  output logic [2:0]                      dbg_rr_ptr
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [PW-1:0] idx_t;

  localparam idx_t NP_M1    = idx_t'(NUM_PORTS - 1);
  localparam idx_t PRIO_IDX = idx_t'(PRIO_PORT);
  localparam idx_t FIRST_NP = (PRIO_PORT == 0) ? idx_t'(1) : idx_t'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  idx_t                  rr_ptr;
  idx_t                  gnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [1:0]            lat_wlen;

  idx_t pick;
  logic prio_hit;
  logic any_valid;
  logic done;
  logic kill_g;
  logic active;

  function automatic idx_t inc_wrap(input idx_t v);
    return (v == NP_M1) ? idx_t'(0) : v + idx_t'(1);
  endfunction

  // Next round-robin start: the port after g, stepping over the walker.
  function automatic idx_t next_np(input idx_t g);
    idx_t n;
    n = inc_wrap(g);
    if (n == PRIO_IDX) n = inc_wrap(n);
    return n;
  endfunction

  // Arbitration: scan upward from rr_ptr for the first valid non-priority
  // port; the walker overrides whatever the scan found.
  always_comb begin
    idx_t cand;
    logic found;
    pick      = rr_ptr;
    found     = 1'b0;
    cand      = rr_ptr;
    prio_hit  = req_valid[PRIO_IDX];
    any_valid = |req_valid;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && cand != PRIO_IDX && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = inc_wrap(cand);
    end
    if (prio_hit) pick = PRIO_IDX;
  end

  // Only the strobe matching the request type counts as completion.
  assign done   = lat_write ? dc_write_done : dc_rvalid;
  assign kill_g = req_kill[gnt];
  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= FIRST_NP;
      gnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wlen  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state     <= BUSY;
            gnt       <= pick;
            lat_write <= req_write[pick];
            lat_addr  <= req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            lat_wlen  <= req_wlen[int'(pick)*2 +: 2];
            if (!prio_hit) rr_ptr <= next_np(pick);
          end
        end
        BUSY: begin
          if (done)        state <= IDLE;
          else if (kill_g) state <= DRAIN;
        end
        DRAIN: begin
          // Abandoned request: wait for D$ to finish, report nothing.
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The D$ request is driven only while a request is in flight, so the
  // IDLE cycle between requests always shows dc_en low.
  assign dc_en         = active;
  assign dc_write_en   = active & lat_write;
  assign dc_in_addr    = active ? lat_addr  : '0;
  assign dc_in_wdata   = active ? lat_wdata : '0;
  assign dc_in_wlen    = active ? lat_wlen  : 2'b00;
  // The walker's accesses are always physical.
  assign dc_virtual_en = virtual_en & ~reset & ~(active & (gnt == PRIO_IDX));

  always_comb begin
    req_ready       = '0;
    resp_rvalid     = '0;
    resp_write_done = '0;
    if (!reset && state == IDLE && any_valid) req_ready[pick] = 1'b1;
    if (!reset && state == BUSY && done && !kill_g) begin
      if (lat_write) resp_write_done[gnt] = 1'b1;
      else           resp_rvalid[gnt]     = 1'b1;
    end
  end

  assign resp_rdata = (|resp_rvalid) ? dc_rdata : '0;

  assign dbg_state  = state;
  assign dbg_rr_ptr = 3'(rr_ptr);

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of requesters sharing one D$ port; legal range 2..8.
REQ-002 SHALL have parameter PRIO_PORT, default 0: fixed-priority port (page-table walker); legal range 0..NUM_PORTS-1.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64: request address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64: read/write data width.
REQ-005 SHALL have ports as follows. The design has one clock and a synchronous, active-high reset.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- virtual_en  in  1  global virtual-mode enable, decoded from SATP.
- req_valid  in  NUM_PORTS  per-port request.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i in slice i.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- req_wlen  in  NUM_PORTS*2  log2 of bytes written.
- req_kill  in  NUM_PORTS  requester abandons its outstanding request.
- req_ready  out  NUM_PORTS  one-cycle accept pulse.
- resp_rdata  out  DATA_WIDTH  read data, shared by all ports.
- resp_rvalid  out  NUM_PORTS  per-port read complete.
- resp_write_done  out  NUM_PORTS  per-port write complete.
- dc_en, dc_write_en  out  1 each  to D$.
- dc_in_addr  out  ADDR_WIDTH  to D$.
- dc_in_wdata  out  DATA_WIDTH  to D$.
- dc_in_wlen  out  2  to D$.
- dc_virtual_en  out  1  D$ virtual mode.
- dc_rdata  in  DATA_WIDTH  from D$.
- dc_rvalid, dc_write_done  in  1 each  from D$.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-007 In IDLE with any req_valid, SHALL grant exactly one port, pulse its req_ready that cycle, latch addr/write/wdata/wlen/port index, and enter BUSY next cycle.
REQ-008 Arbitration: PRIO_PORT wins whenever valid; otherwise the first valid non-priority port searching upward from rr_ptr, modulo NUM_PORTS, skipping PRIO_PORT.
REQ-009 After a non-priority grant to port g, SHALL set rr_ptr to the next non-priority port after g (wrapping); a priority grant leaves rr_ptr unchanged.
REQ-010 In BUSY and DRAIN, SHALL drive dc_en=1 and the latched request on dc_* outputs, held stable until completion.
REQ-011 In IDLE, SHALL drive dc_en=0 and all other dc_* request outputs to 0, guaranteeing at least one dc_en-low cycle between requests.
REQ-012 dc_virtual_en SHALL be virtual_en AND NOT (state != IDLE AND granted port == PRIO_PORT); the walker always runs physical.
REQ-013 Completion is dc_rvalid for a read or dc_write_done for a write; the other strobe SHALL be ignored.
REQ-014 In BUSY on completion, SHALL assert resp_rvalid[g] or resp_write_done[g] combinationally in the same cycle, then return to IDLE.
REQ-015 resp_rdata SHALL equal dc_rdata when any resp_rvalid bit is set, and 0 otherwise.
REQ-016 req_kill[g] in BUSY without completion SHALL move the FSM to DRAIN. DRAIN waits for completion, suppresses all resp_* outputs, then goes to IDLE. A write already issued still completes in D$.
REQ-017 req_kill[g] in the same cycle as completion SHALL suppress the response and go to IDLE.
REQ-018 req_kill on non-granted ports SHALL be ignored.
REQ-019 No new grant SHALL occur outside IDLE; req_ready is 0 in BUSY and DRAIN.
REQ-020 Latency from accept to dc_en=1 SHALL be 1 cycle; from D$ completion to response, 0 cycles.

Reset
REQ-021 reset SHALL force IDLE, all outputs 0, latched request cleared, and rr_ptr = first non-priority port (1 if PRIO_PORT=0, else 0).
REQ-022 reset asserted in BUSY or DRAIN SHALL abandon the request with no response issued; D$ is reset by the same signal.

Verification
REQ-023 Single read: port1 reads 0x1000 and D$ returns 0xDEAD after 3 cycles -> req_ready[1] pulse, dc_en high 3 cycles, resp_rvalid[1]=1 with resp_rdata=0xDEAD, no other resp bits.
REQ-024 Priority plus fairness: ports 0, 1 and 2 all valid continuously -> grant order 0,0,0,… while port 0 stays valid; with port 0 idle the order is 1,2,1,2.
REQ-025 Walker physical: virtual_en=1 and a port-0 grant -> dc_virtual_en=0 while BUSY; a port-2 grant -> dc_virtual_en=1.
REQ-026 Kill: port2 write, req_kill[2] on cycle 1 of BUSY, dc_write_done 2 cycles later -> DRAIN entered, resp_write_done[2] never set, IDLE afterwards.
REQ-027 Kill coincident with dc_rvalid -> no resp_rvalid, IDLE next cycle; mid-BUSY reset -> all outputs 0 next cycle and rr_ptr=1.
